memout_page_buffer: RTL and testbench
=====================================

# memout_page_buffer

Output stage directly downstream of the top-level processC instance. It captures processC's output-memory write port into a two-page internal store and toggles the page on every BX change. It then streams the closed page's written entries, in ascending address order, over a valid/ready interface to the readout or link logic. It replaces the external memout BRAM.

## Interface
- DATA_WIDTH, 32, width of stored word and wr_data/out_data
- ADDR_WIDTH, 5, entry address width; page depth = 2**ADDR_WIDTH
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- wr_ena  in  1  processC outmem_ce0
- wr_wea  in  1  processC outmem_we0
- wr_addr  in  ADDR_WIDTH  processC outmem_address0
- wr_data  in  DATA_WIDTH  processC outmem_d0
- bx_in  in  2  BX currently being written (processC bx_o_V)
- out_valid  out  1  out_data/out_addr/out_bx/out_last valid
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_data  out  DATA_WIDTH  stored word
- out_addr  out  ADDR_WIDTH  entry address of out_data
- out_bx  out  2  BX of the page being streamed
- out_last  out  1  final word of the page
- busy  out  1  reader not IDLE
- overflow  out  1  sticky; page was still being read when it had to be reused

## Operation
- Storage: 2 pages × 2**ADDR_WIDTH words, plus one valid bitmap per page. wpage (1 bit) selects the write page. bx_prev register holds the last bx_in value.
- Write: a write occurs when wr_ena && wr_wea. It stores mem[wpage_eff][wr_addr] <= wr_data and sets the matching bitmap bit. A rewrite of the same address overwrites the word; the entry is streamed once.
- Page close:
  - Close occurs when bx_in != bx_prev, evaluated combinationally in the same cycle.
  - On close: closed = wpage, wpage <= ~wpage, bx_prev <= bx_in. The bitmap of the new write page is cleared.
  - wpage_eff = close ? ~wpage : wpage. A write in the close cycle therefore lands in the new page and survives the clear, because the write takes priority over the clear for that bit.
  - The page toggles on every BX change, independent of BX parity. This covers jumps such as 0→2.
- Reader FSM with states IDLE, LOAD, SHOW:
  - IDLE: on close, latch rpage = closed and out_bx = bx_prev, then go to LOAD.
  - LOAD: priority-encode the lowest set bit of bitmap[rpage]. If none is set, go to IDLE; an empty page emits no words. Otherwise register out_data, out_addr and out_last (out_last = no other bit set), clear that bitmap bit, and go to SHOW.
  - SHOW: out_valid = 1, outputs held stable. When out_ready is high, go to LOAD.
- Close while the reader is not IDLE:
  - The page under readout is the new write page, so the readout is aborted and overflow <= 1.
  - out_valid drops the next cycle. rpage and out_bx are reloaded with the just-closed page, and the FSM goes to LOAD.
  - Words not yet delivered from the aborted page are lost. The bitmap clear above wipes them.
- overflow clears only on reset.

## Timing
- Reset (reset = 0, async) sets the following; writes are ignored while reset is asserted:
  - out_valid, out_data, out_addr, out_bx, out_last, busy and overflow = 0
  - wpage = 0, bx_prev = 0, all bitmaps cleared, FSM in IDLE
- The first bx_in ≠ 0 after reset closes an empty page 0 and produces no output.
- Write to storage takes effect at the sampling edge. A word written in cycle N is readable by LOAD from cycle N+1.
- Close at edge N: LOAD at N+1, out_valid at N+2.
- Accept at edge M: LOAD at M+1, next out_valid at M+2. Peak throughput is 1 word per 2 cycles. out_valid never drops without either a handshake or an abort.
- busy = (state != IDLE), registered.
- A close in the same cycle as a SHOW handshake: the handshake completes, the word counts as delivered, and the close is handled as an abort. overflow is set only if bits remain in rpage.

## Test plan
- Writes to addr 3, 0, 7 with data 0xA3, 0xA0, 0xA7 in BX 1, then bx_in→2 -> stream (0,0xA0), (3,0xA3), (7,0xA7,last); out_bx = 1; first out_valid 2 cycles after close; overflow = 0.
- Same as above with out_ready held low 10 cycles, then pulsed -> out_data/out_addr stable while stalled; exactly 3 handshakes.
- bx_in changes with no writes in the page -> no out_valid; busy high for 1–2 cycles, then IDLE.
- Write addr 5 = 0x11 in the same cycle as the bx_in change, then the next bx change -> the word streams with the new BX, and nothing appears in the previous page.
- 4 words in BX 1, bx→2 with out_ready = 0, 2 words in BX 2, bx→3 -> BX 1 readout aborted, overflow = 1; BX 2 streams exactly its 2 words with out_bx = 2.
- Reset asserted mid-SHOW -> all outputs 0 immediately (async); after release, a following bx change with no writes gives no output.

Source files
------------

// File: rtl/memout_page_buffer_if.sv
// rtl/memout_page_buffer_if.sv - processC write port and readout stream bundle for memout_page_buffer
//
// Purpose: groups the processC output-memory write port, the current BX and
// the valid/ready readout stream with its status flags.
// Signals:
//   wr_ena, wr_wea, wr_addr, wr_data : processC outmem_ce0/we0/address0/d0
//   bx_in                            : BX currently being written
//   out_valid, out_ready             : readout handshake
//   out_data, out_addr, out_bx, out_last : readout word, its address, page BX, end of page
//   busy, overflow                   : reader active, sticky lost-page flag
// Modports: master = producer/consumer side, slave = page buffer.

interface memout_page_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  wr_ena;
    logic                  wr_wea;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            bx_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [1:0]            out_bx;
    logic                  out_last;
    logic                  busy;
    logic                  overflow;

    modport master (
        output wr_ena, wr_wea, wr_addr, wr_data, bx_in, out_ready,
        input  out_valid, out_data, out_addr, out_bx, out_last, busy, overflow
    );

    modport slave (
        input  wr_ena, wr_wea, wr_addr, wr_data, bx_in, out_ready,
        output out_valid, out_data, out_addr, out_bx, out_last, busy, overflow
    );
endinterface

// File: rtl/memout_page_buffer.sv
// rtl/memout_page_buffer.sv - two-page capture of processC output memory with per-BX readout stream
//
// Purpose: captures processC writes into a ping-pong page store, switches
// pages on every BX change and streams the closed page's written entries in
// ascending address order.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : memout_page_buffer_if.slave (write port, bx_in, readout stream, busy, overflow)

module memout_page_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    memout_page_buffer_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Page store and per-page written-entry bitmaps
    logic [DATA_WIDTH-1:0] mem_q    [2][DEPTH];
    logic [DEPTH-1:0]      bitmap_q [2];
    logic [DEPTH-1:0]      bitmap_d [2];
    logic                  wpage_q;
    logic [1:0]            bx_prev_q;

    // Reader state and registered outputs
    state_t                state_q;
    logic                  rpage_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [1:0]            out_bx_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic                  overflow_q;

    logic                  close;
    logic                  wpage_eff;
    logic                  wr_fire;
    logic [DEPTH-1:0]      rd_bits;
    logic                  rd_found;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [DEPTH-1:0]      rd_rest;
    logic                  rd_take;

    assign close     = (bus.bx_in != bx_prev_q);
    // A write in the close cycle already belongs to the new page
    assign wpage_eff = close ? ~wpage_q : wpage_q;
    assign wr_fire   = bus.wr_ena && bus.wr_wea;

    // Lowest set bit of the page under readout, plus what remains after it
    always_comb begin
        rd_bits  = bitmap_q[rpage_q];
        rd_found = 1'b0;
        rd_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rd_bits[i]) begin
                rd_found = 1'b1;
                rd_idx   = ADDR_WIDTH'(i);
            end
        end
        rd_rest = rd_bits & ~(DEPTH'(1) << rd_idx);
    end

    assign rd_take = (state_q == ST_LOAD) && rd_found;

    // Ordering matters: reader clear, then page clear on close, then the
    // write sets its bit so a close-cycle write survives the clear.
    always_comb begin
        bitmap_d[0] = bitmap_q[0];
        bitmap_d[1] = bitmap_q[1];
        if (rd_take) begin
            bitmap_d[rpage_q][rd_idx] = 1'b0;
        end
        if (close) begin
            bitmap_d[~wpage_q] = '0;
        end
        if (wr_fire) begin
            bitmap_d[wpage_eff][bus.wr_addr] = 1'b1;
        end
    end

    // Word storage needs no reset; the bitmaps define what is valid
    always_ff @(posedge clk) begin
        if (reset && wr_fire) begin
            mem_q[wpage_eff][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wpage_q     <= 1'b0;
            bx_prev_q   <= 2'd0;
            bitmap_q[0] <= '0;
            bitmap_q[1] <= '0;
        end else begin
            bitmap_q[0] <= bitmap_d[0];
            bitmap_q[1] <= bitmap_d[1];
            if (close) begin
                wpage_q   <= ~wpage_q;
                bx_prev_q <= bus.bx_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rpage_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_bx_q    <= 2'd0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (close) begin
                        rpage_q  <= wpage_q;
                        out_bx_q <= bx_prev_q;
                        state_q  <= ST_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (close) begin
                        // Page being read is about to become the write page
                        overflow_q <= 1'b1;
                        rpage_q    <= wpage_q;
                        out_bx_q   <= bx_prev_q;
                    end else if (!rd_found) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        out_data_q  <= mem_q[rpage_q][rd_idx];
                        out_addr_q  <= rd_idx;
                        out_last_q  <= (rd_rest == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (close) begin
                        // A simultaneous handshake still delivers the word;
                        // only undelivered entries count as lost.
                        if (!bus.out_ready || (rd_bits != '0)) begin
                            overflow_q <= 1'b1;
                        end
                        out_valid_q <= 1'b0;
                        rpage_q     <= wpage_q;
                        out_bx_q    <= bx_prev_q;
                        state_q     <= ST_LOAD;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_bx    = out_bx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_memout_page_buffer.sv
// tb/tb_memout_page_buffer.sv - scoreboard bench for memout_page_buffer

module tb_memout_page_buffer;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic [1:0]    bx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   hs_cnt;
    exp_t sb[$];

    memout_page_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();

    memout_page_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ifc.wr_ena  = 1'b1;
        ifc.wr_wea  = 1'b1;
        ifc.wr_addr = a;
        ifc.wr_data = d;
        cyc(1);
        ifc.wr_ena  = 1'b0;
        ifc.wr_wea  = 1'b0;
    endtask

    task automatic push(input logic [1:0] b, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic l);
        exp_t e;
        e.bx = b; e.addr = a; e.data = d; e.last = l;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !ifc.busy) break;
            cyc(1);
        end
        chk(name, {sb.size() == 0, ifc.busy}, 2'b10);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, ifc.out_valid, 0);
        chk({tag, "_data"}, ifc.out_data, 0);
        chk({tag, "_addr"}, ifc.out_addr, 0);
        chk({tag, "_bx"}, ifc.out_bx, 0);
        chk({tag, "_last"}, ifc.out_last, 0);
        chk({tag, "_busy"}, ifc.busy, 0);
        chk({tag, "_overflow"}, ifc.overflow, 0);
    endtask

    // Monitor: pop on handshake, compare against the front while stalled
    always @(negedge clk) begin
        if (reset && ifc.out_valid) begin
            if (ifc.out_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_word", {ifc.out_bx, ifc.out_addr, ifc.out_data}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", {ifc.out_bx, ifc.out_addr, ifc.out_data, ifc.out_last},
                        {e.bx, e.addr, e.data, e.last});
                end
            end else if (sb.size() != 0) begin
                chk("stall_hold", {ifc.out_addr, ifc.out_data}, {sb[0].addr, sb[0].data});
            end
        end
    end

    initial begin
        int lat;
        int hs0;
        int busy_cnt;
        int v_cnt;
        checks   = 0;
        failures = 0;
        hs_cnt   = 0;
        reset         = 1'b0;
        ifc.wr_ena    = 1'b0;
        ifc.wr_wea    = 1'b0;
        ifc.wr_addr   = '0;
        ifc.wr_data   = '0;
        ifc.bx_in     = 2'd0;
        ifc.out_ready = 1'b1;
        cyc(2);
        check_zero("reset");
        reset = 1'b1;
        cyc(1);

        // Basic stream: BX 1 page, close by bx 1->2
        ifc.bx_in = 2'd1;
        cyc(1);
        drain("empty_page0");
        wr(5'd3, 32'hA3);
        wr(5'd0, 32'hA0);
        wr(5'd7, 32'hA7);
        push(2'd1, 5'd0, 32'hA0, 1'b0);
        push(2'd1, 5'd3, 32'hA3, 1'b0);
        push(2'd1, 5'd7, 32'hA7, 1'b1);
        ifc.bx_in = 2'd2;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            lat++;
            if (ifc.out_valid) break;
        end
        // negedge before close edge, after close edge (LOAD), then SHOW
        chk("first_valid_latency", lat, 3);
        @(posedge clk);
        #1;
        drain("basic_drain");
        chk("basic_overflow", ifc.overflow, 0);

        // Stalled readout of BX 2 page
        wr(5'd3, 32'hB3);
        wr(5'd0, 32'hB0);
        wr(5'd7, 32'hB7);
        push(2'd2, 5'd0, 32'hB0, 1'b0);
        push(2'd2, 5'd3, 32'hB3, 1'b0);
        push(2'd2, 5'd7, 32'hB7, 1'b1);
        ifc.out_ready = 1'b0;
        ifc.bx_in = 2'd3;
        cyc(12);
        chk("stall_valid", ifc.out_valid, 1);
        hs0 = hs_cnt;
        for (int p = 0; p < 4; p++) begin
            ifc.out_ready = 1'b1;
            cyc(1);
            ifc.out_ready = 1'b0;
            cyc(3);
        end
        chk("stall_handshakes", hs_cnt - hs0, 3);
        chk("stall_sb_empty", sb.size(), 0);
        ifc.out_ready = 1'b1;

        // Empty page close: short busy, no output
        busy_cnt = 0;
        v_cnt = 0;
        ifc.bx_in = 2'd0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (ifc.busy) busy_cnt++;
            if (ifc.out_valid) v_cnt++;
        end
        chk("empty_no_valid", v_cnt, 0);
        chk("empty_busy_short", (busy_cnt >= 1) && (busy_cnt <= 2), 1);

        // Write in the close cycle lands in the new page
        ifc.bx_in = 2'd1;
        wr(5'd5, 32'h11);
        cyc(4);
        chk("closecycle_no_old", sb.size(), 0);
        push(2'd1, 5'd5, 32'h11, 1'b1);
        ifc.bx_in = 2'd2;
        cyc(1);
        drain("closecycle_drain");

        // Abort: BX 1 stalled when BX 2 closes
        ifc.bx_in = 2'd1;
        cyc(1);
        drain("abort_pre");
        wr(5'd1, 32'hD1);
        wr(5'd2, 32'hD2);
        wr(5'd4, 32'hD4);
        wr(5'd9, 32'hD9);
        ifc.out_ready = 1'b0;
        ifc.bx_in = 2'd2;
        wr(5'd6, 32'hC6);
        wr(5'd2, 32'hC2);
        cyc(2);
        chk("abort_stalled_valid", ifc.out_valid, 1);
        chk("abort_pre_overflow", ifc.overflow, 0);
        ifc.bx_in = 2'd3;
        cyc(1);
        push(2'd2, 5'd2, 32'hC2, 1'b0);
        push(2'd2, 5'd6, 32'hC6, 1'b1);
        ifc.out_ready = 1'b1;
        drain("abort_drain");
        chk("abort_overflow", ifc.overflow, 1);

        // Async reset during SHOW
        wr(5'd0, 32'h55);
        ifc.out_ready = 1'b0;
        ifc.bx_in = 2'd0;
        cyc(3);
        chk("pre_reset_valid", ifc.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        ifc.bx_in = 2'd1;
        v_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (ifc.out_valid) v_cnt++;
        end
        chk("post_reset_no_valid", v_cnt, 0);
        chk("post_reset_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
